// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of data_memory between core (c_*) and DMA/debug (d_*).
// Ports: clock, reset (async active-low), c_*/d_* requester ports, mem_* data_memory bus, busy.
// Option: define DMEM_ARB_MISALIGN_CHK_EN to reject misaligned or reserved-size requests (err).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic [1:0]        c_size,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Asynchronous assert, two-flop synchronised release.
    logic rst_s1;
    logic rst_n_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_s1  <= 1'b0;
            rst_n_i <= 1'b0;
        end else begin
            rst_s1  <= 1'b1;
            rst_n_i <= rst_s1;
        end
    end

    logic [1:0]        state;
    logic              last_d;
    logic              sel_d;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [1:0]        l_size;
    logic              rej_q;

    logic              any_req;
    logic              pick_d;
    logic              we_in;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic [1:0]        size_in;

    assign any_req = c_req | d_req;

    // On a tie the side not granted last wins.
    always_comb begin
        pick_d = d_req;
        if (c_req && d_req) begin
            pick_d = ~last_d;
        end
    end

    assign we_in    = pick_d ? d_we    : c_we;
    assign addr_in  = pick_d ? d_addr  : c_addr;
    assign wdata_in = pick_d ? d_wdata : c_wdata;
    assign size_in  = pick_d ? d_size  : c_size;

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    logic rej_in;

    always_comb begin
        rej_in = 1'b0;
        unique case (size_in)
            2'b01:   rej_in = addr_in[0];
            2'b11:   rej_in = (addr_in[1:0] != 2'b00);
            2'b10:   rej_in = 1'b1;
            default: rej_in = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rej_q <= 1'b0;
        end else if (state == IDLE && any_req) begin
            rej_q <= rej_in;
        end
    end
`else
    assign rej_q = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            last_d   <= 1'b1;
            sel_d    <= 1'b0;
            l_we     <= 1'b0;
            l_addr   <= '0;
            l_wdata  <= '0;
            l_size   <= 2'b00;
            c_rdata  <= '0;
            d_rdata  <= '0;
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
        end else begin
            c_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        sel_d   <= pick_d;
                        l_we    <= we_in;
                        l_addr  <= addr_in;
                        l_wdata <= wdata_in;
                        // Reserved size goes out as a word access.
                        l_size  <= (size_in == 2'b10) ? 2'b11 : size_in;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    last_d <= sel_d;
                    state  <= (l_we || rej_q) ? IDLE : RESP;
                end
                RESP: begin
                    if (sel_d) begin
                        d_rdata  <= mem_rdata;
                        d_rvalid <= 1'b1;
                    end else begin
                        c_rdata  <= mem_rdata;
                        c_rvalid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic acc;
    logic issue;

    assign acc   = (state == ACCESS);
    assign issue = acc & ~rej_q;

    assign c_gnt = acc & ~sel_d;
    assign d_gnt = acc & sel_d;
    assign c_err = acc & ~sel_d & rej_q;
    assign d_err = acc & sel_d & rej_q;

    // A rejected request puts nothing on the memory bus.
    assign mem_we    = issue & l_we;
    assign mem_re    = issue & ~l_we;
    assign mem_addr  = issue ? l_addr  : '0;
    assign mem_wdata = issue ? l_wdata : '0;
    assign mem_size  = issue ? l_size  : 2'b00;

    assign busy = (state != IDLE);

endmodule
